tx_controller: RTL and testbench

TX_CONTROLLER -- requirements
Module: tx_controller

---
 rtl/tx_controller_pkg.sv | 17 +
 rtl/tx_controller_conv_enc_k7.sv | 17 +
 rtl/tx_controller.sv | 55 +++++
 tb/tb_tx_controller.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tx_controller_pkg.sv
// Shared constants and helpers for the 802.11a K=7 rate-1/2 convolutional transmitter.
package tx_controller_pkg;

  localparam int K = 7;

  // Tap masks over {u, s1, s2, s3, s4, s5, s6}, u in the MSB.
  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;

  // Encoder history; bit [K-2] is s1 (newest), bit [0] is s6 (oldest).
  typedef logic [K-2:0] hist_t;

  function automatic logic tap_parity(input logic [K-1:0] vec, input logic [K-1:0] mask);
    return ^(vec & mask);
  endfunction

endpackage

// File: rtl/tx_controller_conv_enc_k7.sv
// Combinational A/B generator for the K=7 [133 171] convolutional code.
module conv_enc_k7
  import tx_controller_pkg::*;
(
  input  logic  u,
  input  hist_t state,
  output logic  a,
  output logic  b
);

  logic [K-1:0] w_vec;

  assign w_vec = {u, state};
  assign a     = tap_parity(w_vec, G0);
  assign b     = tap_parity(w_vec, G1);

endmodule

// File: rtl/tx_controller.sv
// Serial convolutional transmitter: one payload bit per two iClk cycles in,
// coded pair A then B out, one coded bit per iClk cycle.
module tx_controller
  import tx_controller_pkg::*;
(
  input  logic iClk,
  input  logic iRst,
  input  logic iEN,
  input  logic iData,
  output logic oData,
  output logic oTX
);

  logic  slwClk;
  hist_t r_hist;
  logic  r_b_hold;
  logic  w_a;
  logic  w_b;

  conv_enc_k7 u_enc (
    .u     (iData),
    .state (r_hist),
    .a     (w_a),
    .b     (w_b)
  );

  // slwClk high before an edge marks a sample edge; low marks the B phase edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      slwClk   <= 1'b0;
      r_hist   <= '0;
      r_b_hold <= 1'b0;
      oData    <= 1'b0;
      oTX      <= 1'b0;
    end else begin
      slwClk <= ~slwClk;
      if (slwClk) begin
        if (iEN) begin
          r_hist   <= {iData, r_hist[K-2:1]};
          oData    <= w_a;
          r_b_hold <= w_b;
          oTX      <= 1'b1;
        end else begin
          // History is deliberately retained so the stream resumes seamlessly.
          oData    <= 1'b0;
          r_b_hold <= 1'b0;
          oTX      <= 1'b0;
        end
      end else begin
        oData <= r_b_hold;
      end
    end
  end

endmodule

// File: tb/tb_tx_controller.sv
// Directed bench for tx_controller: reset, impulse, all-zeros, all-ones,
// fixed pseudo-random stream with an enable gap, and mid-stream reset.
module tb_tx_controller;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic iEN = 1'b0;
  logic iData = 1'b0;
  logic oData;
  logic oTX;

  int n_vec = 0;
  int n_err = 0;

  logic [1:6] m_s = 6'b000000;

  tx_controller dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEN   (iEN),
    .iData (iData),
    .oData (oData),
    .oTX   (oTX)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference encoder written from the generator polynomials directly.
  task automatic model_step(input logic en, input logic u, output logic [1:0] ab);
    if (en) begin
      ab[1] = u ^ m_s[2] ^ m_s[3] ^ m_s[5] ^ m_s[6];
      ab[0] = u ^ m_s[1] ^ m_s[2] ^ m_s[3] ^ m_s[6];
      m_s   = {u, m_s[1:5]};
    end else begin
      ab = 2'b00;
    end
  endtask

  // Caller guarantees the next edge is a sample edge; inputs are scrambled between edges.
  task automatic send_bit(input logic en, input logic d, input logic [1:0] exp_ab, input string tag);
    iEN   = en;
    iData = d;
    tick();
    chk({tag, "_A"}, oData, exp_ab[1]);
    chk({tag, "_txA"}, oTX, en);
    chk({tag, "_slwA"}, dut.slwClk, 1'b0);
    iEN   = 1'($urandom);
    iData = 1'($urandom);
    tick();
    chk({tag, "_B"}, oData, exp_ab[0]);
    chk({tag, "_txB"}, oTX, en);
    chk({tag, "_slwB"}, dut.slwClk, 1'b1);
  endtask

  logic [1:0] imp_tab [9];
  logic [1:0] ones_tab [10];
  logic [69:0] rnd_vec;
  logic [1:0] ab;

  initial begin
    imp_tab  = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
    // Running XOR of the impulse response.
    ones_tab = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    rnd_vec  = 70'h2A5C3F19E7B0D46C1E;

    // Reset wins over an asserted enable.
    iRst = 1'b1;
    iEN  = 1'b1;
    iData = 1'b1;
    tick();
    tick();
    chk("rst_data", oData, 1'b0);
    chk("rst_tx", oTX, 1'b0);
    chk("rst_slw", dut.slwClk, 1'b0);

    iRst = 1'b0;
    iEN  = 1'b0;
    iData = 1'b0;
    tick();
    chk("rel_slw", dut.slwClk, 1'b1);
    chk("rel_data", oData, 1'b0);
    chk("rel_tx", oTX, 1'b0);

    send_bit(1'b0, 1'b1, 2'b00, "idle");

    for (int i = 0; i < 9; i++) begin
      model_step(1'b1, (i == 0) ? 1'b1 : 1'b0, ab);
      send_bit(1'b1, (i == 0) ? 1'b1 : 1'b0, imp_tab[i], $sformatf("imp%0d", i));
    end

    for (int i = 0; i < 70; i++) begin
      model_step(1'b1, 1'b0, ab);
      send_bit(1'b1, 1'b0, 2'b00, $sformatf("zero%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      model_step(1'b1, 1'b1, ab);
      send_bit(1'b1, 1'b1, ones_tab[i], $sformatf("ones%0d", i));
    end

    for (int i = 0; i < 70; i++) begin
      if (i == 35) begin
        for (int g = 0; g < 2; g++) begin
          model_step(1'b0, 1'b1, ab);
          send_bit(1'b0, 1'b1, ab, $sformatf("gap%0d", g));
        end
      end
      model_step(1'b1, rnd_vec[69 - i], ab);
      send_bit(1'b1, rnd_vec[69 - i], ab, $sformatf("rnd%0d", i));
    end

    // Mid-stream reset must clear outputs and history.
    model_step(1'b1, 1'b1, ab);
    send_bit(1'b1, 1'b1, ab, "pre_rst");
    iRst = 1'b1;
    iEN  = 1'b1;
    tick();
    chk("mrst_data", oData, 1'b0);
    chk("mrst_tx", oTX, 1'b0);
    chk("mrst_slw", dut.slwClk, 1'b0);
    iRst = 1'b0;
    tick();
    chk("mrst_rel_slw", dut.slwClk, 1'b1);
    m_s = 6'b000000;
    model_step(1'b1, 1'b0, ab);
    send_bit(1'b1, 1'b0, 2'b00, "post_rst0");
    model_step(1'b1, 1'b1, ab);
    send_bit(1'b1, 1'b1, 2'b11, "post_rst1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
